// File: rtl/instr_fetch_32.sv
// Purpose: in-order instruction fetch: owns the PC, issues credit-limited word reads, buffers responses with their PC.
// Latency: response to inst_valid is 1 cycle (registered buffer); redirect takes effect on the following cycle.
// Backpressure: inst_ready low fills the buffer; requests stop once buffered + in-flight reaches DEPTH.
//
// Ports:
//   clock, reset_n                       rising-edge clock, async active-low reset
//   imem_req_valid/ready/addr            read request channel (addr = PC)
//   imem_resp_valid/data                 in-order read responses, never back-pressured
//   inst_valid/ready/data/pc             instruction handoff to the CPU
//   redirect_valid/target                one-cycle restart pulse from branch/jump resolution
//   fetch_err                            sticky: a misaligned redirect halted fetch
// Optional feature macro: IFETCH_JUMP_PREDECODE_EN (J/JAL predecode, internal redirect).
module instr_fetch_32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_err
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [4:0]    DEPTH_W = 5'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [3:0]    occ;        // buffered instructions
    logic [3:0]    outst;      // accepted reads not yet answered (incl. stale ones)
    logic [3:0]    discard;    // stale responses still to be dropped
    logic [AW-1:0] buf_rd, buf_wr, tag_rd, tag_wr;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   tag_q    [DEPTH];
    logic          pd_vld;
    logic [31:0]   pd_target;

    logic          running, req_fire, pop, bad_redir, redir, resp_drop, buf_push;
    logic [31:0]   redir_pc;
    logic [3:0]    occ_nxt, outst_nxt, discard_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign imem_req_addr = pc;
    assign inst_valid    = (occ != 4'd0);
    assign inst_data     = inst_valid ? buf_data[buf_rd] : 32'd0;
    assign inst_pc       = inst_valid ? buf_pc[buf_rd]   : 32'd0;

    always_comb begin
        running   = (state == RUN);
        req_fire  = imem_req_valid && imem_req_ready;
        pop       = inst_valid && inst_ready;
        bad_redir = running && redirect_valid && (redirect_target[1:0] != 2'b00);
        // External redirect wins over a pending predecoded jump.
        redir     = running && (redirect_valid || pd_vld);
        redir_pc  = redirect_valid ? redirect_target : pd_target;
        resp_drop = (discard != 4'd0);
        // A response landing in a redirect cycle is stale by definition.
        buf_push  = running && imem_resp_valid && !resp_drop && !redir;

        outst_nxt = outst + {3'b000, req_fire} - {3'b000, imem_resp_valid};

        // Everything still in flight after a redirect (including a read
        // accepted this very cycle at the old PC) belongs to the old path.
        if (redir)
            discard_nxt = outst_nxt;
        else if (imem_resp_valid && resp_drop)
            discard_nxt = discard - 4'd1;
        else
            discard_nxt = discard;

        if (redir)
            occ_nxt = 4'd0;
        else
            occ_nxt = occ + {3'b000, buf_push} - {3'b000, pop};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            pc             <= RESET_PC;
            occ            <= 4'd0;
            outst          <= 4'd0;
            discard        <= 4'd0;
            buf_rd         <= '0;
            buf_wr         <= '0;
            tag_rd         <= '0;
            tag_wr         <= '0;
            imem_req_valid <= 1'b0;
            fetch_err      <= 1'b0;
        end else begin
            outst   <= outst_nxt;
            discard <= discard_nxt;
            occ     <= occ_nxt;

            // The tag queue tracks every accepted read, stale or not, so it
            // is never flushed; discarded responses still pop it.
            if (req_fire)
                tag_wr <= ptr_inc(tag_wr);
            if (imem_resp_valid)
                tag_rd <= ptr_inc(tag_rd);

            if (redir) begin
                buf_rd <= '0;
                buf_wr <= '0;
            end else begin
                if (buf_push)
                    buf_wr <= ptr_inc(buf_wr);
                if (pop)
                    buf_rd <= ptr_inc(buf_rd);
            end

            if (bad_redir) begin
                state     <= HALT;
                fetch_err <= 1'b1;
            end

            if (redir && !bad_redir)
                pc <= redir_pc;
            else if (req_fire)
                pc <= pc + 32'd4;

            // Registered credit check on next-cycle counts keeps the request
            // valid free of any combinational path from the inputs.
            imem_req_valid <= running && !bad_redir &&
                              (({1'b0, occ_nxt} + {1'b0, outst_nxt}) < DEPTH_W);
        end
    end

    // Storage arrays carry no reset; occupancy and pointers define validity.
    always_ff @(posedge clock) begin
        if (req_fire)
            tag_q[tag_wr] <= pc;
        if (buf_push) begin
            buf_data[buf_wr] <= imem_resp_data;
            buf_pc[buf_wr]   <= tag_q[tag_rd];
        end
    end

`ifdef IFETCH_JUMP_PREDECODE_EN
    logic [31:0] tag_pc_plus4;
    logic        is_jump;

    assign tag_pc_plus4 = tag_q[tag_rd] + 32'd4;
    assign is_jump      = (imem_resp_data[31:26] == 6'h02) || (imem_resp_data[31:26] == 6'h03);

    // A J/JAL written into the buffer redirects fetch on the next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pd_vld    <= 1'b0;
            pd_target <= 32'd0;
        end else begin
            pd_vld <= buf_push && is_jump;
            if (buf_push && is_jump)
                pd_target <= {tag_pc_plus4[31:28], imem_resp_data[25:0], 2'b00};
        end
    end
`else
    assign pd_vld    = 1'b0;
    assign pd_target = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_32.sv
// Purpose: directed self-checking bench for instr_fetch_32 with an in-order memory model of programmable latency.
// Latency: memory answers lat cycles after acceptance; outputs are sampled 1 time unit after the rising edge.
// Backpressure: inst_ready and imem_req_ready are driven directly by the stimulus sequence.
module tb_instr_fetch_32;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_err;

    always #5 clock = ~clock;

    instr_fetch_32 #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .fetch_err      (fetch_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic        jmode = 1'b0;
    logic [31:0] req_log  [$];
    logic [31:0] got_pc   [$];
    logic [31:0] got_data [$];
    logic [31:0] pend_addr[$];
    int          pend_due [$];
    int          n_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jmode && a == 32'h0)
            return 32'h0800_0040;       // J to 0x100
        return 32'hC000_0000 | a;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i >= q.size())
            return 32'hDEAD_BEEF;
        return q[i];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        tick(2);
        req_log.delete();
        got_pc.delete();
        got_data.delete();
        reset_n = 1'b1;
    endtask

    // Memory model and transaction monitor.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (imem_req_valid && imem_req_ready) begin
                    req_log.push_back(imem_req_addr);
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + lat);
                end
                if (inst_valid && inst_ready) begin
                    got_pc.push_back(inst_pc);
                    got_data.push_back(inst_data);
                end
            end
            @(posedge clock);
            #1;
            cyc++;
            imem_resp_valid = 1'b0;
            if (!reset_n) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] exp_t4 [6];
        exp_t4 = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204, 32'h208};

        reset_n         = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        inst_ready      = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;

        // Reset state
        tick(2);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr",  imem_req_addr,       32'h0);
        check("rst_inst_valid", 32'(inst_valid),    32'd0);
        check("rst_inst_data", inst_data,           32'd0);
        check("rst_inst_pc",   inst_pc,             32'd0);
        check("rst_fetch_err", 32'(fetch_err),      32'd0);

        // Streaming with 1-cycle memory
        lat = 1;
        do_reset();
        tick(1);
        check("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_c1_req_addr",  imem_req_addr,       32'h0);
        check("t1_c1_inst_valid", 32'(inst_valid),    32'd0);
        tick(1);
        check("t1_c2_req_addr",  imem_req_addr,       32'h4);
        check("t1_c2_inst_valid", 32'(inst_valid),    32'd0);
        tick(1);
        check("t1_c3_inst_valid", 32'(inst_valid),    32'd1);
        check("t1_c3_inst_pc",   inst_pc,             32'h0);
        check("t1_c3_inst_data", inst_data,           32'hC000_0000);
        tick(10);
        for (int i = 0; i < 6; i++) begin
            check("t1_req_seq", q_at(req_log, i),  32'(4 * i));
            check("t1_pc_seq",  q_at(got_pc, i),   32'(4 * i));
            check("t1_data_seq", q_at(got_data, i), 32'hC000_0000 | 32'(4 * i));
        end

        // Consumer stall: requests stop at DEPTH credits, nothing lost
        inst_ready = 1'b0;
        do_reset();
        tick(20);
        check("t2_req_count",  32'(req_log.size()), 32'(DEPTH));
        check("t2_req_valid",  32'(imem_req_valid), 32'd0);
        check("t2_inst_valid", 32'(inst_valid),     32'd1);
        check("t2_inst_pc",    inst_pc,             32'h0);
        inst_ready = 1'b1;
        tick(20);
        for (int i = 0; i < 8; i++)
            check("t2_pc_seq", q_at(got_pc, i), 32'(4 * i));

        // Redirect with 1 buffered and 2 outstanding (memory slowed)
        inst_ready = 1'b0;
        lat = 2;
        do_reset();
        tick(2);                // cycle 2
        lat = 6;
        tick(2);                // cycle 4: word 0 buffered, 0x4/0x8 in flight
        imem_req_ready = 1'b0;
        check("t3_pre_inst_valid", 32'(inst_valid), 32'd1);
        check("t3_pre_inst_pc",    inst_pc,         32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick(1);                // cycle 5
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        check("t3_flush_inst_valid", 32'(inst_valid), 32'd0);
        check("t3_req_valid",        32'(imem_req_valid), 32'd1);
        check("t3_req_addr",         imem_req_addr,    32'h100);
        tick(20);
        check("t3_pc0",   q_at(got_pc, 0),   32'h100);
        check("t3_data0", q_at(got_data, 0), 32'hC000_0100);
        check("t3_pc1",   q_at(got_pc, 1),   32'h104);
        check("t3_pc2",   q_at(got_pc, 2),   32'h108);

        // Redirect coinciding with request handshake, response and pop
        do_reset();
        tick(5);                // cycle 5: req 0x10 fires, resp 0xC arrives, 0x8 popped
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        tick(1);
        redirect_valid = 1'b0;
        check("t4_inst_valid", 32'(inst_valid), 32'd0);
        check("t4_req_addr",   imem_req_addr,   32'h200);
        tick(10);
        for (int i = 0; i < 6; i++)
            check("t4_pc_seq", q_at(got_pc, i), exp_t4[i]);
        check("t4_stale_req", q_at(req_log, 4), 32'h10);
        check("t4_new_req",   q_at(req_log, 5), 32'h200);

        // Misaligned redirect halts until reset
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        tick(1);
        redirect_valid = 1'b0;
        check("t5_fetch_err",  32'(fetch_err),      32'd1);
        check("t5_req_valid",  32'(imem_req_valid), 32'd0);
        check("t5_inst_valid", 32'(inst_valid),     32'd0);
        n_req = req_log.size();
        tick(2);
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick(1);
        redirect_valid = 1'b0;
        tick(5);
        check("t5_err_sticky",    32'(fetch_err),      32'd1);
        check("t5_halt_req",      32'(imem_req_valid), 32'd0);
        check("t5_halt_no_reqs",  32'(req_log.size()), 32'(n_req));
        check("t5_halt_inst",     32'(inst_valid),     32'd0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_err_clear", 32'(fetch_err),      32'd0);
        check("t5_rst_req_valid", 32'(imem_req_valid), 32'd0);
        do_reset();
        tick(1);
        check("t5_restart_valid", 32'(imem_req_valid), 32'd1);
        check("t5_restart_addr",  imem_req_addr,       32'h0);

`ifdef IFETCH_JUMP_PREDECODE_EN
        // Predecoded J at 0x0 targets 0x100
        jmode = 1'b1;
        do_reset();
        tick(12);
        check("t6_j_pc",     q_at(got_pc, 0),   32'h0);
        check("t6_j_data",   q_at(got_data, 0), 32'h0800_0040);
        check("t6_tgt_pc",   q_at(got_pc, 1),   32'h100);
        check("t6_tgt_data", q_at(got_data, 1), 32'hC000_0100);
        jmode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
